// File: rtl/aer_spike_arbiter.sv
// Event FIFO: holds accepted AER words between the arbiter and the output handshake.
// Latency: a pushed word is visible at rd_dat the cycle after the push.
// Backpressure: full is reported to the writer; pushing while full is not allowed.
module aer_event_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign rd_dat = mem[rd_ptr];

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// Spike arbiter: round-robin over the source core array plus control-event injection,
// serialised through a small FIFO into a 4-phase AER REQ/ACK stream.
// Latency: spike accepted in cycle t raises REQ at t+2; backpressure: SRC_ACK/CTRL_ACK drop while the FIFO is full or busy.
module aer_spike_arbiter #(
  parameter int SRC_W      = 16,
  parameter int SRC_H      = 16,
  parameter int SRC_C      = 4,
  parameter int AER_WIDTH  = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [SRC_W*SRC_H-1:0]                    SRC_REQ,
  input  logic [SRC_W*SRC_H*$clog2(SRC_C)-1:0]      SRC_CH,
  output logic [SRC_W*SRC_H-1:0]                    SRC_ACK,
  input  logic                                      CTRL_REQ,
  input  logic [1:0]                                CTRL_TYPE,
  output logic                                      CTRL_ACK,
  output logic                                      MAP_IN_AERIN_REQ,
  output logic [AER_WIDTH-1:0]                      MAP_IN_AERIN_EVENT,
  output logic [AER_WIDTH-3:0]                      MAP_IN_AERIN_IDX,
  input  logic                                      MAP_IN_AERIN_ACK,
  output logic                                      BUSY
);

  localparam int N      = SRC_W * SRC_H;
  localparam int C_BITS = $clog2(SRC_C);
  localparam int Y_BITS = $clog2(SRC_H);
  localparam int X_BITS = $clog2(SRC_W);
  localparam int PTR_W  = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_WAIT_LO = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W:0]       cand;
  logic                 grant_vld;
  logic [PTR_W-1:0]     grant_idx;
  logic [C_BITS-1:0]    spike_ch;
  logic [Y_BITS-1:0]    spike_y;
  logic [X_BITS-1:0]    spike_x;
  logic [AER_WIDTH-1:0] spike_word;
  logic [AER_WIDTH-1:0] ctrl_word;
  logic                 spike_push;
  logic                 ctrl_push;
  logic                 fifo_push;
  logic [AER_WIDTH-1:0] fifo_push_dat;
  logic                 fifo_pop;
  logic [AER_WIDTH-1:0] fifo_rd_dat;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 req_nxt;
  logic [AER_WIDTH-1:0] event_nxt;

  // Round-robin search: first requesting core at or after rr_ptr, wrapping at N-1.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(N)) begin
        cand = cand - (PTR_W+1)'(N);
      end
      if (!grant_vld && SRC_REQ[cand[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  // Build the neuron event word from the granted core's position and channel.
  always_comb begin
    spike_ch   = SRC_CH[grant_idx*C_BITS +: C_BITS];
    spike_y    = Y_BITS'(32'(grant_idx) / SRC_W);
    spike_x    = X_BITS'(32'(grant_idx) % SRC_W);
    spike_word = {2'b00, spike_ch, spike_y, spike_x};
    ctrl_word  = {CTRL_TYPE, {(AER_WIDTH-2){1'b1}}};
  end

  // Handshake decode: one spike per cycle when there is room; control events only
  // when everything upstream and downstream is quiet, which gives barrier ordering.
  always_comb begin
    spike_push = grant_vld && !fifo_full && !rst;
    SRC_ACK    = '0;
    if (spike_push) begin
      SRC_ACK[grant_idx] = 1'b1;
    end
    CTRL_ACK      = CTRL_REQ && fifo_empty && (SRC_REQ == '0) && (state == ST_IDLE) && !rst;
    ctrl_push     = CTRL_ACK && (CTRL_TYPE != 2'b00);
    fifo_push     = spike_push || ctrl_push;
    fifo_push_dat = ctrl_push ? ctrl_word : spike_word;
  end

  // Advance the round-robin pointer past the core that was just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (spike_push) begin
      rr_ptr <= (grant_idx == PTR_W'(N-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  aer_event_fifo #(
    .W     (AER_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (fifo_push_dat),
    .pop      (fifo_pop),
    .rd_dat   (fifo_rd_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Output FSM next-state: pop into the output register, then a full 4-phase handshake.
  always_comb begin
    state_nxt = state;
    req_nxt   = MAP_IN_AERIN_REQ;
    event_nxt = MAP_IN_AERIN_EVENT;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          event_nxt = fifo_rd_dat;
          req_nxt   = 1'b1;
          state_nxt = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (MAP_IN_AERIN_ACK) begin
          req_nxt   = 1'b0;
          state_nxt = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!MAP_IN_AERIN_ACK) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output FSM registers; reset drops REQ and discards the in-flight event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      MAP_IN_AERIN_REQ   <= 1'b0;
      MAP_IN_AERIN_EVENT <= '0;
    end else begin
      state              <= state_nxt;
      MAP_IN_AERIN_REQ   <= req_nxt;
      MAP_IN_AERIN_EVENT <= event_nxt;
    end
  end

  assign MAP_IN_AERIN_IDX = MAP_IN_AERIN_EVENT[AER_WIDTH-3:0];
  assign BUSY             = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_aer_spike_arbiter.sv
module tb_aer_spike_arbiter;
  localparam int W     = 16;
  localparam int H     = 16;
  localparam int C     = 4;
  localparam int AW    = 12;
  localparam int DEPTH = 4;
  localparam int N     = W * H;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   src_req;
  logic [2*N-1:0] src_ch;
  logic [N-1:0]   src_ack;
  logic           ctrl_req;
  logic [1:0]     ctrl_type;
  logic           ctrl_ack;
  logic           map_req;
  logic [AW-1:0]  map_ev;
  logic [AW-3:0]  map_idx;
  logic           map_ack;
  logic           busy;

  aer_spike_arbiter #(
    .SRC_W(W), .SRC_H(H), .SRC_C(C), .AER_WIDTH(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .SRC_REQ            (src_req),
    .SRC_CH             (src_ch),
    .SRC_ACK            (src_ack),
    .CTRL_REQ           (ctrl_req),
    .CTRL_TYPE          (ctrl_type),
    .CTRL_ACK           (ctrl_ack),
    .MAP_IN_AERIN_REQ   (map_req),
    .MAP_IN_AERIN_EVENT (map_ev),
    .MAP_IN_AERIN_IDX   (map_idx),
    .MAP_IN_AERIN_ACK   (map_ack),
    .BUSY               (busy)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: FIFO contents double as the scoreboard queue.
  int            m_state = 0;   // 0 idle, 1 wait_hi, 2 wait_lo
  int            m_ptr = 0;
  logic [AW-1:0] m_cur = '0;
  logic [AW-1:0] sb_q[$];
  logic [AW-1:0] emitted[$];
  int            n_acc = 0;
  int            n_cack = 0;
  int            n_stall = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            rise_cyc = 0;
  logic          req_q = 1'b0;

  // Stimulus-side state.
  int       pend[N];
  logic [1:0] chv[N];
  bit       ack_hold = 1'b1;
  bit       ack_dly = 1'b0;
  logic     req_d = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0]  exp_ack;
    logic          exp_cack;
    logic [AW-1:0] ev;
    bit            any;
    int            g;
    cyc++;
    if (rst) begin
      chk("rst_src_ack", src_ack, '0);
      chk("rst_ctrl_ack", ctrl_ack, 0);
      m_state = 0;
      m_ptr   = 0;
      sb_q.delete();
    end else begin
      chk("req", map_req, (m_state == 1));
      if (m_state == 1) begin
        chk("event", map_ev, m_cur);
        chk("idx", map_idx, m_cur[AW-3:0]);
      end
      chk("busy", busy, (sb_q.size() != 0 || m_state != 0));
      any = 1'b0;
      g = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!any && src_req[j]) begin
          any = 1'b1;
          g = j;
        end
      end
      exp_ack = '0;
      if (any && sb_q.size() < DEPTH) exp_ack[g] = 1'b1;
      chk("src_ack", src_ack, exp_ack);
      if (any && exp_ack == '0) n_stall++;
      exp_cack = ctrl_req && sb_q.size() == 0 && src_req == '0 && m_state == 0;
      chk("ctrl_ack", ctrl_ack, exp_cack);
      if (ctrl_req && ctrl_ack) n_cack++;
      case (m_state)
        0: if (sb_q.size() != 0) begin m_cur = sb_q.pop_front(); m_state = 1; end
        1: if (map_ack) m_state = 2;
        2: if (!map_ack) m_state = 0;
        default: m_state = 0;
      endcase
      if (exp_ack != '0) begin
        ev = {2'b00, src_ch[g*2 +: 2], 4'(g / W), 4'(g % W)};
        sb_q.push_back(ev);
        m_ptr = (g + 1) % N;
        n_acc++;
        acc_cyc = cyc;
      end
      if (exp_cack && ctrl_type != 2'b00) sb_q.push_back({ctrl_type, 10'h3FF});
    end
    if (map_req && !req_q) begin
      emitted.push_back(map_ev);
      rise_cyc = cyc;
    end
    req_q = map_req;
  end

  task automatic upd_src();
    for (int i = 0; i < N; i++) begin
      src_req[i]       = (pend[i] != 0);
      src_ch[i*2 +: 2] = chv[i];
    end
  endtask

  task automatic step();
    logic [N-1:0] xfer;
    logic         cx;
    @(negedge clk);
    xfer = src_req & src_ack;
    cx   = ctrl_req & ctrl_ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (xfer[i] && pend[i] > 0) pend[i] = pend[i] - 1;
    if (cx) ctrl_req = 1'b0;
    upd_src();
    if (ack_hold)     map_ack = 1'b0;
    else if (ack_dly) map_ack = req_d;
    else              map_ack = map_req;
    req_d = map_req;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      step();
      if (src_req == '0 && !ctrl_req && sb_q.size() == 0 && m_state == 0 && !busy) done = 1'b1;
    end
    chk("drain_done", done, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    req_d = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] e;
    logic [AW-1:0] t4_exp [4];
    rst = 1'b1; src_req = '0; src_ch = '0; ctrl_req = 1'b0; ctrl_type = 2'b00; map_ack = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; chv[i] = 2'b00; end
    run(3);
    rst = 1'b0;
    step();
    chk("rst_event", map_ev, 0);
    chk("rst_idx", map_idx, 0);
    chk("rst_req", map_req, 0);
    chk("rst_busy", busy, 0);

    // Single spike from core 17, channel 2, ACK one cycle behind REQ.
    ack_hold = 1'b0; ack_dly = 1'b1; emitted.delete();
    chv[17] = 2'd2; pend[17] = 1; upd_src();
    drain(40);
    chk("t1_count", emitted.size(), 1);
    e = (emitted.size() != 0) ? emitted[0] : '0;
    chk("t1_event", e, 12'h211);
    chk("t1_latency", rise_cyc - acc_cyc, 2);

    // All cores requesting, immediate ACK.
    do_reset();
    ack_dly = 1'b0; emitted.delete(); n_acc = 0; n_stall = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 1000; chv[i] = 2'(i % 4); end
    upd_src();
    run(600);
    chk("t2_stall", (n_stall > 0), 1);
    chk("t2_acc_min", (n_acc >= 150), 1);
    for (int i = 0; i < N; i++) begin pend[i] = 0; chv[i] = 2'b00; end
    upd_src();
    drain(100);
    chk("t2_emit_cnt", emitted.size(), n_acc);
    for (int k = 0; k < emitted.size(); k++) begin
      e = {2'b00, 2'(k % 4), 8'(k % 256)};
      chk("t2_order", emitted[k], e);
    end

    // ACK held low: one in flight plus a full FIFO.
    do_reset();
    ack_hold = 1'b1; ack_dly = 1'b1; emitted.delete(); n_acc = 0;
    for (int i = 0; i < 6; i++) pend[i] = 1;
    upd_src();
    run(20);
    chk("t3_acc", n_acc, 5);
    chk("t3_src_ack", src_ack, '0);
    ack_hold = 1'b0;
    drain(100);
    chk("t3_emit_cnt", emitted.size(), 6);
    for (int k = 0; k < emitted.size(); k++) chk("t3_order", emitted[k], 12'(k));

    // Control event behind three pending spikes.
    do_reset();
    emitted.delete(); n_cack = 0;
    pend[3] = 1; pend[9] = 1; pend[40] = 1;
    chv[3] = 2'd1; chv[9] = 2'd2; chv[40] = 2'd3;
    ctrl_type = 2'b01; ctrl_req = 1'b1;
    upd_src();
    drain(100);
    t4_exp = '{12'h103, 12'h209, 12'h328, 12'h7FF};
    chk("t4_emit_cnt", emitted.size(), 4);
    for (int k = 0; k < 4 && k < emitted.size(); k++) chk("t4_order", emitted[k], t4_exp[k]);
    chk("t4_cack", n_cack, 1);

    // Type-00 control event is acknowledged and dropped.
    do_reset();
    emitted.delete(); n_cack = 0;
    ctrl_type = 2'b00; ctrl_req = 1'b1;
    drain(20);
    run(5);
    chk("t5_cack", n_cack, 1);
    chk("t5_no_req", emitted.size(), 0);

    // Reset during WAIT_HI with two events queued.
    do_reset();
    ack_hold = 1'b1; emitted.delete();
    pend[5] = 1; pend[6] = 1; pend[7] = 1;
    upd_src();
    run(4);
    chk("t6_req_hi", map_req, 1);
    chk("t6_busy_hi", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_req_lo", map_req, 0);
    chk("t6_busy_lo", busy, 0);
    ack_hold = 1'b0; ack_dly = 1'b1; req_d = 1'b0; emitted.delete();
    pend[200] = 1; pend[2] = 1;
    upd_src();
    drain(100);
    chk("t6_emit_cnt", emitted.size(), 2);
    e = (emitted.size() > 0) ? emitted[0] : '0;
    chk("t6_first", e, 12'h002);
    e = (emitted.size() > 1) ? emitted[1] : '0;
    chk("t6_second", e, 12'h0C8);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
